// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles the instruction-cache, data-cache and RAM signals seen by the
// memory arbiter.
//
// Handshake semantics (applies to both requester sides):
//   A requester raises iREN (or dREN/dWEN) and holds it, together with its
//   address/data, until it sees its wait signal low for one cycle. Wait low
//   means the transfer completed in that cycle and iload/dload carry the
//   read data. Dropping the request before wait goes low abandons the
//   access. The RAM completes the current strobe in any cycle where
//   ramready is high.
//
// Modports:
//   slave  - used by the arbiter (answers cache requests, drives the RAM)
//   master - used by the environment (caches and RAM model)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  // Instruction-cache side
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;

  // Data-cache side
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dwait;
  logic [ADDR_W-1:0] dload;

  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  logic              ramready;

  modport slave (
    input  iREN, iaddr,
    output iwait, iload,
    input  dREN, dWEN, daddr, dstore,
    output dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramready
  );

  modport master (
    output iREN, iaddr,
    input  iwait, iload,
    output dREN, dWEN, daddr, dstore,
    input  dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramready
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Merges instruction-cache and data-cache traffic onto a single-ported RAM,
// one transaction at a time. The data side wins by default; a saturating
// starvation counter forces an instruction grant once the instruction side
// has been kept waiting STARVE_LIMIT cycles.
//
// Ports:
//   CLK          - system clock, rising edge
//   nRST         - synchronous active-low reset
//   bus          - mem_arbiter_if.slave: cache request/response + RAM signals
//   state_dbg    - current FSM state (0 IDLE, 1 SERVE_I, 2 SERVE_D)
//   starve_count - current starvation counter value
//
// Timing: a grant is taken from the state register, so a request first
// seen in IDLE drives the RAM on the following cycle. Every transaction is
// followed by at least one IDLE cycle.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  mem_arbiter_if.slave bus,
  output logic [1:0]  state_dbg,
  output logic [3:0]  starve_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [3:0]        LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [3:0]        CNT_MAX   = 4'hF;
  localparam logic [ADDR_W-1:0] ZERO_WORD = '0;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       starve;
  logic       d_req;

  assign d_req  = bus.dREN | bus.dWEN;
  assign starve = (cnt >= LIMIT);

  // Read data is a straight copy of the RAM bus; the wait signals qualify it.
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

  assign state_dbg    = state;
  assign starve_count = cnt;

  // -------------------------------------------------------------------------
  // State and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Starvation counter: counts cycles the instruction side is requesting but
  // not granted. While SERVE_I is in flight it holds its value, and it
  // clears once the instruction access completes or the request goes away.
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_next = cnt;
    if (!bus.iREN) begin
      cnt_next = 4'd0;
    end else if (state == SERVE_I) begin
      if (bus.ramready) begin
        cnt_next = 4'd0;
      end
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = ZERO_WORD;
    bus.ramstore = ZERO_WORD;

    unique case (state)
      IDLE: begin
        // starve only matters here; it never preempts a data access
        if (starve && bus.iREN) begin
          state_next = SERVE_I;
        end else if (d_req) begin
          state_next = SERVE_D;
        end else if (bus.iREN) begin
          state_next = SERVE_I;
        end
      end

      SERVE_I: begin
        if (!bus.iREN) begin
          // requester abandoned the fetch: no strobe, no completion
          state_next = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (bus.ramready) begin
            bus.iwait  = 1'b0;
            state_next = IDLE;
          end
        end
      end

      SERVE_D: begin
        if (!d_req) begin
          state_next = IDLE;
        end else begin
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          // write takes precedence when both enables are high
          if (bus.dWEN) begin
            bus.ramWEN = 1'b1;
          end else begin
            bus.ramREN = 1'b1;
          end
          if (bus.ramready) begin
            bus.dwait  = 1'b0;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Inputs change 1 time unit after a rising
// edge; outputs are checked 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_I    = 2'd1;
  localparam logic [1:0] S_D    = 2'd2;

  logic       CLK;
  logic       nRST;
  logic [1:0] state_dbg;
  logic [3:0] starve_count;

  int checks;
  int errors;

  mem_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_arbiter #(
    .ADDR_W       (AW),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .bus          (bus),
    .state_dbg    (state_dbg),
    .starve_count (starve_count)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---- driver tasks ----
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramready = 1'b0;
  endtask

  // ---- comparison ----
  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // waits are never both low
  task automatic check_waits(input string tag);
    check({tag, "_wait_excl"}, 32'(bus.iwait | bus.dwait), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    nRST = 1'b0;

    // ---------------- reset ----------------
    next_cycle();
    next_cycle();
    settle();
    check("rst_state",    32'(state_dbg), 32'(S_IDLE));
    check("rst_cnt",      32'(starve_count), 32'd0);
    check("rst_iwait",    32'(bus.iwait), 32'd1);
    check("rst_dwait",    32'(bus.dwait), 32'd1);
    check("rst_ramREN",   32'(bus.ramREN), 32'd0);
    check("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
    check("rst_ramaddr",  bus.ramaddr, 32'h0);
    check("rst_ramstore", bus.ramstore, 32'h0);
    nRST = 1'b1;

    // ---------------- single instruction fetch ----------------
    next_cycle();
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h0000_0040;
    bus.ramready = 1'b1;
    bus.ramload  = 32'hDEAD_BEEF;
    settle();
    check("if_idle_state",  32'(state_dbg), 32'(S_IDLE));
    check("if_idle_ramREN", 32'(bus.ramREN), 32'd0);
    check("if_idle_iwait",  32'(bus.iwait), 32'd1);
    next_cycle();
    settle();
    check("if_state",   32'(state_dbg), 32'(S_I));
    check("if_ramREN",  32'(bus.ramREN), 32'd1);
    check("if_ramaddr", bus.ramaddr, 32'h0000_0040);
    check("if_iwait",   32'(bus.iwait), 32'd0);
    check("if_iload",   bus.iload, 32'hDEAD_BEEF);
    check("if_cnt",     32'(starve_count), 32'd1);
    check_waits("if");
    next_cycle();
    bus.iREN = 1'b0;
    settle();
    check("if_done_state", 32'(state_dbg), 32'(S_IDLE));
    check("if_done_cnt",   32'(starve_count), 32'd0);
    check("if_done_iwait", 32'(bus.iwait), 32'd1);

    // ---------------- simultaneous I and D, slow RAM ----------------
    next_cycle();
    bus.ramready = 1'b0;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h0000_0100;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h0000_0200;
    bus.ramload  = 32'hCAFE_0001;
    settle();
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      settle();
      check("both_state",   32'(state_dbg), 32'(S_D));
      check("both_ramaddr", bus.ramaddr, 32'h0000_0200);
      check("both_ramREN",  32'(bus.ramREN), 32'd1);
      check("both_dwait",   32'(bus.dwait), 32'd1);
      check("both_iwait",   32'(bus.iwait), 32'd1);
      check("both_cnt",     32'(starve_count), 32'(c));
    end
    next_cycle();
    bus.ramready = 1'b1;
    settle();
    check("both_d_done_dwait", 32'(bus.dwait), 32'd0);
    check("both_d_done_iwait", 32'(bus.iwait), 32'd1);
    check("both_d_dload",      bus.dload, 32'hCAFE_0001);
    check("both_d_cnt",        32'(starve_count), 32'd4);
    check_waits("both_d");
    next_cycle();
    bus.dREN = 1'b0;
    settle();
    check("both_gap_state", 32'(state_dbg), 32'(S_IDLE));
    check("both_gap_dwait", 32'(bus.dwait), 32'd1);
    check("both_gap_cnt",   32'(starve_count), 32'd5);
    next_cycle();
    settle();
    check("both_i_state",   32'(state_dbg), 32'(S_I));
    check("both_i_ramaddr", bus.ramaddr, 32'h0000_0100);
    check("both_i_iwait",   32'(bus.iwait), 32'd0);
    check("both_i_cnt",     32'(starve_count), 32'd6);
    next_cycle();
    bus.iREN = 1'b0;
    settle();
    check("both_end_state", 32'(state_dbg), 32'(S_IDLE));
    check("both_end_cnt",   32'(starve_count), 32'd0);

    // ---------------- data write (dREN and dWEN both high) ----------------
    next_cycle();
    bus.ramready = 1'b0;
    bus.dREN     = 1'b1;
    bus.dWEN     = 1'b1;
    bus.daddr    = 32'h0000_0080;
    bus.dstore   = 32'h1234_5678;
    settle();
    next_cycle();
    settle();
    check("wr_state",    32'(state_dbg), 32'(S_D));
    check("wr_ramWEN",   32'(bus.ramWEN), 32'd1);
    check("wr_ramREN",   32'(bus.ramREN), 32'd0);
    check("wr_ramaddr",  bus.ramaddr, 32'h0000_0080);
    check("wr_ramstore", bus.ramstore, 32'h1234_5678);
    check("wr_dwait_hi", 32'(bus.dwait), 32'd1);
    next_cycle();
    bus.ramready = 1'b1;
    settle();
    check("wr_dwait_lo", 32'(bus.dwait), 32'd0);
    check("wr_ramWEN2",  32'(bus.ramWEN), 32'd1);
    next_cycle();
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    settle();
    check("wr_end_state",  32'(state_dbg), 32'(S_IDLE));
    check("wr_end_ramWEN", 32'(bus.ramWEN), 32'd0);

    // ---------------- starvation ----------------
    next_cycle();
    bus.ramready = 1'b1;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h0000_0300;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h0000_0400;
    settle();
    next_cycle();
    settle();
    check("stv_d1_state", 32'(state_dbg), 32'(S_D));
    check("stv_d1_dwait", 32'(bus.dwait), 32'd0);
    check("stv_d1_cnt",   32'(starve_count), 32'd1);
    next_cycle();
    settle();
    check("stv_gap1_state", 32'(state_dbg), 32'(S_IDLE));
    check("stv_gap1_cnt",   32'(starve_count), 32'd2);
    next_cycle();
    settle();
    check("stv_d2_state", 32'(state_dbg), 32'(S_D));
    check("stv_d2_cnt",   32'(starve_count), 32'd3);
    next_cycle();
    settle();
    check("stv_gap2_state", 32'(state_dbg), 32'(S_IDLE));
    check("stv_gap2_cnt",   32'(starve_count), 32'd4);
    next_cycle();
    settle();
    check("stv_forced_state",   32'(state_dbg), 32'(S_I));
    check("stv_forced_ramaddr", bus.ramaddr, 32'h0000_0300);
    check("stv_forced_iwait",   32'(bus.iwait), 32'd0);
    check("stv_forced_dwait",   32'(bus.dwait), 32'd1);
    check("stv_forced_cnt",     32'(starve_count), 32'd5);
    check_waits("stv_forced");
    next_cycle();
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    settle();
    check("stv_end_state", 32'(state_dbg), 32'(S_IDLE));
    check("stv_end_cnt",   32'(starve_count), 32'd0);

    // ---------------- abort during SERVE_D ----------------
    next_cycle();
    bus.ramready = 1'b0;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h0000_0500;
    settle();
    next_cycle();
    bus.dREN     = 1'b0;
    bus.ramready = 1'b1;
    settle();
    check("abt_state",  32'(state_dbg), 32'(S_D));
    check("abt_ramREN", 32'(bus.ramREN), 32'd0);
    check("abt_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("abt_dwait",  32'(bus.dwait), 32'd1);
    next_cycle();
    settle();
    check("abt_next_state", 32'(state_dbg), 32'(S_IDLE));

    // ---------------- reset during SERVE_I ----------------
    bus.ramready = 1'b0;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h0000_0600;
    settle();
    next_cycle();
    settle();
    check("rmid_state",  32'(state_dbg), 32'(S_I));
    check("rmid_ramREN", 32'(bus.ramREN), 32'd1);
    check("rmid_cnt",    32'(starve_count), 32'd1);
    nRST = 1'b0;
    next_cycle();
    settle();
    check("rmid_after_state",  32'(state_dbg), 32'(S_IDLE));
    check("rmid_after_ramREN", 32'(bus.ramREN), 32'd0);
    check("rmid_after_iwait",  32'(bus.iwait), 32'd1);
    check("rmid_after_cnt",    32'(starve_count), 32'd0);
    nRST     = 1'b1;
    bus.iREN = 1'b0;
    next_cycle();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and beside the data cache; merges their miss/writeback traffic onto the single-ported RAM interface.
- Arbitrates one transaction at a time.
- Data side has priority by default; a starvation counter guarantees forward progress for instruction fetches.
- Returns RAM data and per-requester wait signals upstream.

Parameters:
- ADDR_W, 32, width of all address and data words.
- STARVE_LIMIT, 4, consecutive cycles an instruction request may lose arbitration before it is forced to win; legal range 1..15.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- nRST  input  1  reset, synchronous, active-low.
- iREN  input  1  instruction-cache read request (held until iwait low).
- iaddr  input  ADDR_W  instruction read address.
- iwait  output  1  low for exactly the cycle instruction data is valid.
- iload  output  ADDR_W  instruction read data.
- dREN  input  1  data-cache read request.
- dWEN  input  1  data-cache write request.
- daddr  input  ADDR_W  data address.
- dstore  input  ADDR_W  data write value.
- dwait  output  1  low for exactly the cycle the data access completes.
- dload  output  ADDR_W  data read data.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramaddr  output  ADDR_W  RAM address.
- ramstore  output  ADDR_W  RAM write data.
- ramload  input  ADDR_W  RAM read data.
- ramready  input  1  RAM completes the current access this cycle.

Behaviour:
- Reset: when nRST is low at a rising edge, state goes to IDLE and the starvation counter clears to 0.
- Outputs while in reset/IDLE: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- iload and dload are combinational copies of ramload at all times.
- States:
  - IDLE: no grant.
  - SERVE_I: instruction side granted.
  - SERVE_D: data side granted.
- Grant comes from the state register. A request first seen in IDLE gets its RAM strobes on the next cycle, so minimum latency from request to wait-low is 2 cycles when ramready is already high.
- IDLE transitions:
  - If starve=1 and iREN=1, go to SERVE_I.
  - Else if dREN or dWEN, go to SERVE_D.
  - Else if iREN, go to SERVE_I.
  - Else stay in IDLE.
- SERVE_I outputs: ramREN=1, ramaddr=iaddr.
- SERVE_D outputs:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN=1: ramWEN=1, ramREN=0. Write wins if dREN and dWEN are both high.
  - Else ramREN=1.
- Completion: in SERVE_x with ramready=1, drive the granted side's wait low combinationally that same cycle; next state is IDLE. There is no back-to-back grant, so IDLE always separates transactions.
- Abort: in SERVE_x, if the granted requester drops its request, deassert both RAM strobes that cycle, keep waits high, and go to IDLE. This holds even if ramready=1.
- Non-granted requester: its wait stays 1. Its address and data are ignored.
- Starvation counter (4 bits, saturating):
  - Increments each cycle iREN=1 and the state is not SERVE_I.
  - Clears when iREN=0, or on SERVE_I completion.
  - starve = (count >= STARVE_LIMIT).
  - Only the IDLE decision uses starve. It never preempts an in-flight data transaction.
- Reset mid-transaction: synchronous return to IDLE. RAM strobes drop the cycle after the reset edge sample. No completion is signalled.
- Wait-high rule: iwait and dwait are never both low in the same cycle.

Test Plan:
- Reset, then iREN=1 with iaddr=0x0000_0040 and ramready stuck at 1:
  - cycle 1 in SERVE_I with ramREN=1, ramaddr=0x40.
  - iwait=0 that cycle, iload equals ramload (0xDEAD_BEEF).
  - back in IDLE after.
- iREN and dREN raised in the same cycle, with ramready low for 3 cycles then high:
  - data served first (ramaddr=daddr); dwait low for 1 cycle.
  - then the instruction is served.
- dREN=dWEN=1 with daddr=0x80 and dstore=0x1234_5678: ramWEN=1, ramREN=0, ramstore=0x1234_5678; dwait low when ramready is high.
- Starvation, STARVE_LIMIT=4:
  - iREN held while the data side issues continuous requests.
  - counter reaches 4 and the next IDLE decision grants SERVE_I even though dREN=1.
  - counter returns to 0 after the instruction completes.
- Abort: in SERVE_D, drop dREN while ramready=1. Required: ramREN=0 that cycle, dwait stays 1, next state IDLE.
- nRST pulled low for one cycle during SERVE_I with ramready=0: next cycle ramREN=0, iwait=1, counter=0.
